// File: rtl/axis_packet_dropper_pkg.sv
// axis_packet_dropper_pkg: shared FSM encoding and saturating counter helper
package axis_packet_dropper_pkg;
    typedef enum logic [1:0] {SOP, PASS, DROP} state_t;
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] max_v;
        max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= max_v) ? v : v + 64'd1;
    endfunction
endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: two-entry AXI-Stream register slice with registered valid/data and ready
module axis_skid_buffer #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic [KEEP_WIDTH-1:0] s_tkeep,
    input  logic                  s_tlast,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic [KEEP_WIDTH-1:0] m_tkeep,
    output logic                  m_tlast,
    output logic                  m_tvalid,
    input  logic                  m_tready
);
    localparam int W = DATA_WIDTH + KEEP_WIDTH + 1;
    logic [W-1:0] main_q, main_n, skid_q, skid_n, s_beat;
    logic main_v, main_vn, skid_v, skid_vn, s_fire;
    assign s_beat = {s_tlast, s_tkeep, s_tdata};
    assign {m_tlast, m_tkeep, m_tdata} = main_q;
    assign m_tvalid = main_v;
    always_comb begin
        main_n  = main_q;
        main_vn = main_v;
        skid_n  = skid_q;
        skid_vn = skid_v;
        s_fire  = s_tvalid && s_tready;
        if (m_tready || !main_v) begin
            main_vn = skid_v || s_fire;
            main_n  = skid_v ? skid_q : (s_fire ? s_beat : main_q);
            skid_vn = 1'b0;
        end else if (s_fire) begin
            skid_vn = 1'b1;
            skid_n  = s_beat;
        end
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            main_q   <= '0;
            main_v   <= 1'b0;
            skid_q   <= '0;
            skid_v   <= 1'b0;
            s_tready <= 1'b0;
        end else begin
            main_q   <= main_n;
            main_v   <= main_vn;
            skid_q   <= skid_n;
            skid_v   <= skid_vn;
            s_tready <= !skid_vn;
        end
    end
endmodule

// File: rtl/axis_packet_dropper.sv
// axis_packet_dropper: packet-aligned AXI-Stream dropper with stall/discard modes and saturating counters
module axis_packet_dropper
    import axis_packet_dropper_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int DISCARD    = 1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  dropn,
    input  logic                  clr_cnt,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [CNT_WIDTH-1:0]  pass_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
    output logic                  in_drop
);
    state_t state, state_n;
    logic run, drop_sop, stall, fire, buf_valid, buf_ready, pass_inc, drop_inc;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= SOP;
            run   <= 1'b0;
        end else begin
            state <= state_n;
            run   <= 1'b1;
        end
    end
    always_comb begin
        state_n       = state;
        drop_sop      = (state == SOP) && !dropn;
        in_drop       = run && ((drop_sop && DISCARD != 0) || state == DROP);
        stall         = drop_sop && DISCARD == 0;
        s_axis_tready = in_drop ? 1'b1 : (!stall && buf_ready);
        buf_valid     = s_axis_tvalid && !in_drop && !stall;
        fire          = s_axis_tvalid && s_axis_tready;
        pass_inc      = fire && s_axis_tlast && !in_drop;
        drop_inc      = fire && s_axis_tlast && in_drop;
        if (fire)
            state_n = s_axis_tlast ? SOP : (in_drop ? DROP : PASS);
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pass_cnt <= '0;
            drop_cnt <= '0;
        end else if (clr_cnt) begin
            pass_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (pass_inc)
                pass_cnt <= CNT_WIDTH'(sat_inc(64'(pass_cnt), CNT_WIDTH));
            if (drop_inc)
                drop_cnt <= CNT_WIDTH'(sat_inc(64'(drop_cnt), CNT_WIDTH));
        end
    end
    axis_skid_buffer #(.DATA_WIDTH(DATA_WIDTH), .KEEP_WIDTH(KEEP_WIDTH)) u_skid (
        .clk      (clk),
        .rstn     (rstn),
        .s_tdata  (s_axis_tdata),
        .s_tkeep  (s_axis_tkeep),
        .s_tlast  (s_axis_tlast),
        .s_tvalid (buf_valid),
        .s_tready (buf_ready),
        .m_tdata  (m_axis_tdata),
        .m_tkeep  (m_axis_tkeep),
        .m_tlast  (m_axis_tlast),
        .m_tvalid (m_axis_tvalid),
        .m_tready (m_axis_tready)
    );
endmodule

// File: tb/tb_axis_packet_dropper.sv
// tb_axis_packet_dropper: directed bench for discard-mode and stall-mode droppers
module tb_axis_packet_dropper;
    typedef logic [36:0] beat_t;
    logic clk = 1'b0, rstn = 1'b1;
    always #5 clk = ~clk;
    int checks = 0, failures = 0, out_cnt = 0, stalls = 0;
    logic dropn = 1'b0, clr = 1'b0, s_last = 1'b0, s_valid = 1'b0, m_ready = 1'b1;
    logic [31:0] s_data = '0;
    logic [3:0] s_keep = '0;
    logic s_ready, m_last, m_valid, in_drop;
    logic [31:0] m_data;
    logic [3:0] m_keep;
    logic [2:0] pass_cnt, drop_cnt;
    logic b_dropn = 1'b1, b_clr = 1'b0, b_s_last = 1'b0, b_s_valid = 1'b0, b_m_ready = 1'b1;
    logic [31:0] b_s_data = '0;
    logic [3:0] b_s_keep = '0;
    logic b_s_ready, b_m_last, b_m_valid, b_in_drop;
    logic [31:0] b_m_data;
    logic [3:0] b_m_keep;
    logic [2:0] b_pass_cnt, b_drop_cnt;
    beat_t exp_q[$];
    beat_t last_beat, hold_beat;
    logic hold = 1'b0, done = 1'b0;

    axis_packet_dropper #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .DISCARD(1), .CNT_WIDTH(3)) dut (
        .clk(clk), .rstn(rstn), .dropn(dropn), .clr_cnt(clr),
        .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tlast(s_last),
        .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
        .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tlast(m_last),
        .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
        .pass_cnt(pass_cnt), .drop_cnt(drop_cnt), .in_drop(in_drop)
    );
    axis_packet_dropper #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .DISCARD(0), .CNT_WIDTH(3)) dut_stall (
        .clk(clk), .rstn(rstn), .dropn(b_dropn), .clr_cnt(b_clr),
        .s_axis_tdata(b_s_data), .s_axis_tkeep(b_s_keep), .s_axis_tlast(b_s_last),
        .s_axis_tvalid(b_s_valid), .s_axis_tready(b_s_ready),
        .m_axis_tdata(b_m_data), .m_axis_tkeep(b_m_keep), .m_axis_tlast(b_m_last),
        .m_axis_tvalid(b_m_valid), .m_axis_tready(b_m_ready),
        .pass_cnt(b_pass_cnt), .drop_cnt(b_drop_cnt), .in_drop(b_in_drop)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always begin
        @(negedge clk);
        #3;
        if (rstn) begin
            if (hold)
                chk("hold_stable", {m_valid, m_last, m_keep, m_data}, {1'b1, hold_beat});
            hold = m_valid && !m_ready;
            hold_beat = {m_last, m_keep, m_data};
            if (m_valid && m_ready) begin
                out_cnt++;
                chk("beat_expected", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0)
                    chk("out_beat", {m_last, m_keep, m_data}, exp_q.pop_front());
            end
        end else
            hold = 1'b0;
    end

    task automatic send_pkt(input int n, input logic dn0, input logic dn1, input logic [7:0] id, input logic clr_last);
        beat_t bt;
        for (int b = 0; b < n; b++) begin
            bt = {b == n - 1, (b == n - 1) ? 4'($urandom_range(14) + 1) : 4'hf, id, 8'(b), 16'($urandom)};
            {s_last, s_keep, s_data} = bt;
            s_valid = 1'b1;
            dropn = (b == 0) ? dn0 : dn1;
            clr = clr_last && b == n - 1;
            #1;
            for (int t = 0; !s_ready; t++) begin
                if (t > 300) begin
                    $display("FAIL s_ready_timeout observed=0 expected=1");
                    $fatal(1, "timeout");
                end
                stalls++;
                @(negedge clk);
                #1;
            end
            chk("in_drop", in_drop, !dn0);
            if (dn0)
                exp_q.push_back(bt);
            last_beat = bt;
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        clr = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 400 && exp_q.size() != 0; t++)
            @(negedge clk);
        chk("drained", exp_q.size(), 0);
    endtask

    task automatic clear();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        beat_t bb[3];
        int base, np, nd, n;
        logic dn;
        #1 rstn = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_in_drop", in_drop, 0);
        chk("rst_m_out", {m_valid, m_last, m_keep, m_data}, 0);
        chk("rst_cnts", {pass_cnt, drop_cnt}, 0);
        chk("rst_b_s_ready", b_s_ready, 0);
        @(negedge clk);
        rstn = 1'b1;
        dropn = 1'b1;
        repeat (2) @(negedge clk);

        for (int p = 0; p < 3; p++)
            send_pkt(4, 1'b1, 1'b1, 8'(p + 1), 1'b0);
        chk("pt_latency_beat", {m_valid, m_last, m_keep, m_data}, {1'b1, last_beat});
        chk("pt_pass_cnt", pass_cnt, 3);
        chk("pt_drop_cnt", drop_cnt, 0);
        drain();
        chk("pt_out_cnt", out_cnt, 12);
        chk("pt_idle", m_valid, 0);

        clear();
        base = out_cnt;
        stalls = 0;
        send_pkt(5, 1'b0, 1'b1, 8'h10, 1'b0);
        chk("dc_no_stall", stalls, 0);
        chk("dc_drop_cnt", drop_cnt, 1);
        chk("dc_in_drop_off", in_drop, 0);
        send_pkt(4, 1'b1, 1'b1, 8'h11, 1'b0);
        drain();
        chk("dc_out_cnt", out_cnt - base, 4);
        chk("dc_cnts", {pass_cnt, drop_cnt}, {3'd1, 3'd1});

        bb[0] = {1'b0, 4'hf, 32'ha0a0_0001};
        bb[1] = {1'b0, 4'hf, 32'hb1b1_0002};
        bb[2] = {1'b1, 4'h3, 32'hc2c2_0003};
        {b_s_last, b_s_keep, b_s_data} = bb[0];
        b_s_valid = 1'b1;
        b_dropn = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("st_s_ready", b_s_ready, 0);
            chk("st_m_valid", b_m_valid, 0);
            chk("st_in_drop", b_in_drop, 0);
            @(negedge clk);
        end
        b_dropn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            {b_s_last, b_s_keep, b_s_data} = bb[i];
            #1;
            chk("st_fwd_ready", b_s_ready, 1);
            @(negedge clk);
            chk("st_fwd_beat", {b_m_valid, b_m_last, b_m_keep, b_m_data}, {1'b1, bb[i]});
        end
        b_s_valid = 1'b0;
        chk("st_cnts", {b_pass_cnt, b_drop_cnt}, {3'd1, 3'd0});

        clear();
        send_pkt(6, 1'b1, 1'b0, 8'h20, 1'b0);
        send_pkt(3, 1'b0, 1'b0, 8'h21, 1'b0);
        drain();
        chk("mt_cnts", {pass_cnt, drop_cnt}, {3'd1, 3'd1});

        m_ready = 1'b0;
        fork
            send_pkt(4, 1'b1, 1'b1, 8'h30, 1'b0);
            begin
                @(negedge clk);
                #2;
                chk("bp_ready_main_full", s_ready, 1);
                @(negedge clk);
                #2;
                chk("bp_ready_skid_full", s_ready, 0);
                chk("bp_head", {m_valid, m_last, m_keep, m_data}, {1'b1, exp_q[0]});
                repeat (3) @(negedge clk);
                chk("bp_ready_held_low", s_ready, 0);
                m_ready = 1'b1;
            end
        join
        drain();

        clear();
        np = 0;
        nd = 0;
        stalls = 0;
        fork
            begin
                for (int p = 0; p < 1000; p++) begin
                    n = (p % 10 == 0) ? 1 : int'($urandom_range(16, 1));
                    dn = $urandom_range(3) != 0;
                    send_pkt(n, dn, 1'($urandom_range(1)), 8'(p), 1'b0);
                    if (dn) np++;
                    else nd++;
                    if ($urandom_range(3) == 0)
                        @(negedge clk);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    m_ready = 1'($urandom_range(1));
                end
            end
        join
        m_ready = 1'b1;
        drain();
        chk("rb_pass_cnt", pass_cnt, (np > 7) ? 7 : np);
        chk("rb_drop_cnt", drop_cnt, (nd > 7) ? 7 : nd);
        chk("rb_backpressure_seen", 64'(stalls > 0), 1);

        clear();
        for (int p = 0; p < 9; p++) begin
            send_pkt(2, 1'b1, 1'b1, 8'(p + 64), 1'b0);
            if (p == 6)
                chk("sat_reach7", pass_cnt, 7);
        end
        chk("sat_hold7", pass_cnt, 7);
        send_pkt(2, 1'b1, 1'b1, 8'h50, 1'b1);
        chk("clr_with_tlast", pass_cnt, 0);
        send_pkt(1, 1'b1, 1'b1, 8'h51, 1'b0);
        send_pkt(1, 1'b0, 1'b0, 8'h52, 1'b0);
        drain();
        chk("after_clr_cnts", {pass_cnt, drop_cnt}, {3'd1, 3'd1});

        dropn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            {s_last, s_keep, s_data} = {1'b0, 4'hf, 32'hdead_0000 + 32'(i)};
            s_valid = 1'b1;
            #1;
            chk("mr_accept", s_ready, 1);
            exp_q.push_back({s_last, s_keep, s_data});
            @(negedge clk);
        end
        rstn = 1'b0;
        exp_q.delete();
        s_valid = 1'b0;
        dropn = 1'b0;
        #1;
        chk("mr_s_ready", s_ready, 0);
        chk("mr_m_out", {m_valid, m_last, m_keep, m_data}, 0);
        chk("mr_cnts", {pass_cnt, drop_cnt}, 0);
        chk("mr_in_drop", in_drop, 0);
        @(negedge clk);
        rstn = 1'b1;
        dropn = 1'b1;
        @(negedge clk);
        send_pkt(3, 1'b1, 1'b1, 8'h60, 1'b0);
        drain();
        chk("mr_recover_cnts", {pass_cnt, drop_cnt}, {3'd1, 3'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axis_packet_dropper.md
# axis_packet_dropper

Parametrised, packet-aligned AXI-Stream dropper for placement ahead of an AXI-Stream switch port. The block samples a drop request only at packet boundaries, so a packet is always forwarded or removed whole and never truncated mid-packet. It supports two drop modes, back-pressure (stall) or discard (sink), and keeps saturating pass/drop packet counters. The output is registered through a full-throughput skid buffer.

## Interface
- DATA_WIDTH, 64, tdata width in bits; must be a multiple of 8
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width
- DISCARD, 1, 1 = dropped packets are accepted and thrown away; 0 = dropped packets are held off with tready low
- CNT_WIDTH, 32, width of each packet counter
- clk  input  1  single clock for all logic
- rstn  input  1  asynchronous active-low reset
- dropn  input  1  0 requests that the next packet be dropped; sampled only on the first beat of a packet
- clr_cnt  input  1  synchronous clear of both counters
- s_axis_tdata  input  DATA_WIDTH  slave data
- s_axis_tkeep  input  KEEP_WIDTH  slave byte enables
- s_axis_tlast  input  1  slave end of packet
- s_axis_tvalid  input  1  slave valid
- s_axis_tready  output  1  slave ready
- m_axis_tdata  output  DATA_WIDTH  master data
- m_axis_tkeep  output  KEEP_WIDTH  master byte enables
- m_axis_tlast  output  1  master end of packet
- m_axis_tvalid  output  1  master valid
- m_axis_tready  input  1  master ready
- pass_cnt  output  CNT_WIDTH  number of packets forwarded
- drop_cnt  output  CNT_WIDTH  number of packets discarded
- in_drop  output  1  high while the current packet is being discarded

## Operation
- **States.**
  - SOP: at a packet boundary.
  - PASS: mid-packet, forwarding.
  - DROP: mid-packet, discarding (DISCARD=1 only).
- **SOP with dropn=1.** The beat routes to the skid buffer. s_axis_tready equals the buffer's ready.
  - Accepted beat with tlast=0: go to PASS.
  - Accepted beat with tlast=1: stay in SOP.
- **SOP with dropn=0, DISCARD=1.**
  - s_axis_tready=1 and the beat is discarded.
  - tlast=0: go to DROP.
  - tlast=1: stay in SOP and count one dropped packet.
- **SOP with dropn=0, DISCARD=0.**
  - s_axis_tready=0 and nothing is consumed.
  - The block waits until dropn returns to 1.
- **PASS.** Beats route to the buffer and dropn is ignored. An accepted tlast beat returns the state to SOP.
- **DROP.**
  - s_axis_tready=1, beats are discarded, dropn is ignored.
  - An accepted tlast beat returns to SOP and increments drop_cnt.
  - in_drop=1 in DROP, and also combinationally at SOP when dropn=0 and DISCARD=1.
- **pass_cnt** increments when a tlast beat of a forwarded packet is accepted at the slave side.
- **Counters** saturate at all-ones and never wrap. clr_cnt has priority over an increment in the same cycle.
- **Skid buffer.** Two entries: main plus skid.
  - It is registered on both valid/data and ready paths.
  - Its ready is high when the skid entry is empty.
  - tdata, tkeep and tlast pass through unmodified.

## Timing
- **Reset values** (rstn low, asynchronous):
  - state = SOP, buffer empty
  - m_axis_tvalid=0, m_axis_tdata/tkeep/tlast=0
  - s_axis_tready=0 while in reset
  - pass_cnt=0, drop_cnt=0, in_drop=0
- **Latency.** Slave acceptance to m_axis_tvalid is 1 cycle. Throughput is 1 beat/cycle with m_axis_tready held high.
- **Back-pressure.** When m_axis_tready drops, at most one extra beat is absorbed into the skid entry. s_axis_tready then falls on the next cycle.
- **AXI rule.** m_axis_tvalid, once asserted, is held with stable data until m_axis_tready is high.
- **Counter visibility.** Counter updates are visible the cycle after the accepted tlast beat.
- **Reset mid-packet.** The in-flight packet remainder is lost. Both counters reset to 0. Upstream is responsible for resynchronising to packet boundaries.
- **Toggling dropn mid-packet** has no effect on the current packet.

## Structure
- **Shared package:** state encoding (SOP/PASS/DROP) and a saturating-increment function usable by other counters in the design.
- **Sub-module:** axis_skid_buffer, parametrised by DATA_WIDTH and KEEP_WIDTH, reusable elsewhere.
- **Top level:** FSM, routing and counters.

## Test plan
- **Pass-through:** dropn=1, 3 packets of 4 beats, tready=1.
  - Expect 12 identical beats out, 1-cycle latency, pass_cnt=3, drop_cnt=0.
- **Discard mode:** DISCARD=1, dropn=0 on the SOP beat of a 5-beat packet, then dropn=1 for the next packet.
  - Expect no output for the first packet and s_axis_tready=1 throughout it.
  - Expect drop_cnt=1, second packet forwarded intact, pass_cnt=1.
- **Stall mode:** DISCARD=0, dropn=0 for 10 cycles with valid SOP beat held.
  - Expect s_axis_tready=0 and m_axis_tvalid=0 for all 10 cycles.
  - After dropn=1, the packet is forwarded intact.
- **Mid-packet dropn toggle:** dropn goes 1→0 on beat 2 of a 6-beat packet.
  - Expect all 6 beats out; the next packet is dropped.
- **Random back-pressure:** 50% m_axis_tready over 1000 random packets of 1-16 beats, including single-beat packets.
  - Expect no lost or duplicated beats and stable data while stalled.
- **Counter saturation and clear:** CNT_WIDTH=3, 9 passed packets.
  - Expect pass_cnt saturates at 7.
  - clr_cnt coincident with a tlast beat gives 0.
  - rstn pulse mid-packet gives all outputs at reset values.
